// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 16-bit memory between an
// instruction-fetch requester (I) and a data requester (D). Accesses are
// serialised through IDLE -> ACCESS -> RESP, with WAIT_STATES extra ACCESS
// cycles. A pending memory dump is issued only in an IDLE cycle with no request.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin conflict resolution;
// when undefined, D always wins a conflict).
module mem_port_arbiter #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  input  logic              dump_req,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_dump,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t              state;
  state_t              state_next;
  owner_t              owner;
  logic [3:0]          cnt;
  logic                dump_pending;
  logic                lat_wr;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                take;
  logic                grant_d;
  logic                dump_fire;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t              last_owner;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic, grant decision, memory strobes and done pulses
  always_comb begin
    state_next = state;
    take       = 1'b0;
    grant_d    = 1'b0;
    dump_fire  = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_req || d_req) begin
          take       = 1'b1;
          state_next = S_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          if (i_req && d_req) grant_d = (last_owner == OWN_I);
          else                grant_d = d_req;
`else
          grant_d = d_req;
`endif
        end else if (dump_pending) begin
          dump_fire = 1'b1;
        end
      end
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_wr = lat_wr;
        if (cnt == 4'd0) state_next = S_RESP;
      end
      S_RESP: begin
        i_done     = (owner == OWN_I);
        d_done     = (owner == OWN_D);
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign mem_dump  = dump_fire;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // Transaction latch, wait-state counter and per-requester read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_I;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (take) begin
        owner     <= grant_d ? OWN_D : OWN_I;
        lat_addr  <= grant_d ? d_addr : i_addr;
        lat_wr    <= grant_d & d_wr;
        lat_wdata <= grant_d ? d_wdata : '0;
        cnt       <= 4'(WAIT_STATES);
      end
      if (state == S_ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!lat_wr) begin
          if (owner == OWN_D) d_rdata <= mem_rdata;
          else                i_rdata <= mem_rdata;
        end
      end
    end
  end

  // Dump request capture; a new request on the same edge as the issue wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dump_pending <= 1'b0;
    else      dump_pending <= dump_req | (dump_pending & ~dump_fire);
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was granted last for round-robin conflict resolution
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last_owner <= OWN_I;
    else if (take) last_owner <= grant_d ? OWN_D : OWN_I;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: one instance with no wait states
// and one with WAIT_STATES=3, each attached to its own behavioural memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // Instance 0 (WAIT_STATES = 0)
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, dump_req = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_done, d_done, mem_en, mem_wr, mem_dump, busy;

  // Instance 3 (WAIT_STATES = 3)
  logic        d3_req = 1'b0;
  logic [15:0] d3_addr = '0;
  logic [15:0] i3_rdata, d3_rdata, mem3_addr, mem3_wdata, mem3_rdata;
  logic        i3_done, d3_done, mem3_en, mem3_wr, mem3_dump, busy3;

  logic [15:0] mem0 [0:65535];
  logic [15:0] mem3 [0:65535];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_STATES(0), .ADDR_W(16), .DATA_W(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .dump_req(dump_req),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_dump(mem_dump),
    .busy(busy)
  );

  mem_port_arbiter #(.WAIT_STATES(3), .ADDR_W(16), .DATA_W(16)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(1'b0), .i_addr(16'h0000), .i_rdata(i3_rdata), .i_done(i3_done),
    .d_req(d3_req), .d_wr(1'b0), .d_addr(d3_addr), .d_wdata(16'h0000),
    .d_rdata(d3_rdata), .d_done(d3_done), .dump_req(1'b0),
    .mem_en(mem3_en), .mem_wr(mem3_wr), .mem_addr(mem3_addr),
    .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata), .mem_dump(mem3_dump),
    .busy(busy3)
  );

  // Behavioural single-port memories: combinational read, clocked write
  assign mem_rdata  = mem0[mem_addr];
  assign mem3_rdata = mem3[mem3_addr];

  always @(posedge clk) begin
    if (mem_en && mem_wr) mem0[mem_addr] <= mem_wdata;
    if (mem3_en && mem3_wr) mem3[mem3_addr] <= mem3_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned en_cnt;
  logic        exp_d;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem0[i] = '0;
      mem3[i] = '0;
    end
    mem0[16'h0010] = 16'hBEEF;
    mem0[16'hFFFF] = 16'h7777;
    mem3[16'h0040] = 16'hABCD;

    // Reset state
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_done", {30'd0, i_done, d_done}, 32'd0);
    check("rst_rdata", {i_rdata, d_rdata}, 32'd0);
    check("rst_mem_out", {mem_addr, mem_wdata}, 32'd0);
    check("rst_dump_wr", {30'd0, mem_dump, mem_wr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // I read of 0x0010, no wait states
    i_req = 1'b1; i_addr = 16'h0010;
    check("i_rd_c0_busy", {31'd0, busy}, 32'd0);
    tick();
    check("i_rd_c1_en", {31'd0, mem_en}, 32'd1);
    check("i_rd_c1_addr", {16'd0, mem_addr}, 32'h0010);
    check("i_rd_c1_done", {31'd0, i_done}, 32'd0);
    tick();
    check("i_rd_c2_done", {30'd0, i_done, d_done}, 32'd2);
    check("i_rd_c2_rdata", {16'd0, i_rdata}, 32'hBEEF);
    check("i_rd_c2_en", {31'd0, mem_en}, 32'd0);
    i_req = 1'b0;
    tick();
    check("i_rd_c3_busy", {31'd0, busy}, 32'd0);

    // I read at the top address
    i_req = 1'b1; i_addr = 16'hFFFF;
    tick();
    check("wrap_addr", {16'd0, mem_addr}, 32'h0000FFFF);
    tick();
    check("wrap_rdata", {15'd0, i_done, i_rdata}, 32'h00017777);
    i_req = 1'b0;
    tick();

    // D write 0x0020 <= 0x1234, then back-to-back D read
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    tick();
    check("d_wr_c1", {mem_en, mem_wr, 14'd0, mem_wdata}, 32'hC0001234);
    tick();
    check("d_wr_done", {30'd0, i_done, d_done}, 32'd1);
    check("d_wr_rdata_kept", {16'd0, d_rdata}, 32'd0);
    d_wr = 1'b0;
    tick();
    check("d_b2b_idle", {busy, d_done, 14'd0, d_rdata}, 32'd0);
    check("mem_written", {16'd0, mem0[16'h0020]}, 32'h1234);
    tick();
    check("d_rd_c1", {mem_en, mem_wr, 14'd0, mem_addr}, 32'h80000020);
    tick();
    check("d_rd_done", {15'd0, d_done, d_rdata}, 32'h00011234);
    check("i_rdata_kept", {15'd0, i_done, i_rdata}, 32'h00007777);
    d_req = 1'b0;
    tick();

    // Dump pulsed during a D write's ACCESS
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0030; d_wdata = 16'h5555;
    tick();
    dump_req = 1'b1;
    check("dump_c1_none", {31'd0, mem_dump}, 32'd0);
    tick();
    dump_req = 1'b0;
    check("dump_c2_resp", {30'd0, mem_dump, d_done}, 32'd1);
    d_req = 1'b0; d_wr = 1'b0;
    tick();
    check("dump_c3_fire", {31'd0, mem_dump}, 32'd1);
    check("dump_has_write", {16'd0, mem0[16'h0030]}, 32'h5555);
    check("dump_d_rdata", {16'd0, d_rdata}, 32'h1234);
    tick();
    check("dump_c4_once", {31'd0, mem_dump}, 32'd0);
    tick();
    check("dump_c5_once", {31'd0, mem_dump}, 32'd0);

    // Reset in the middle of ACCESS
    i_req = 1'b1; i_addr = 16'h0010;
    tick();
    check("mid_pre_en", {31'd0, mem_en}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_en_busy", {30'd0, mem_en, busy}, 32'd0);
    check("mid_rst_done", {30'd0, i_done, d_done}, 32'd0);
    check("mid_rst_rdata", {i_rdata, d_rdata}, 32'd0);
    i_req = 1'b0;
    tick();
    check("mid_rst_hold", {29'd0, i_done, busy, mem_en}, 32'd0);
    rst = 1'b1;
    d_req = 1'b1; d_addr = 16'h0020;
    check("mid_idle", {31'd0, busy}, 32'd0);
    tick();
    tick();
    check("mid_fresh_done", {15'd0, d_done, d_rdata}, 32'h00011234);
    d_req = 1'b0;
    tick();

    // Conflict: both requests held from reset release
    rst = 1'b0;
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
    tick();
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (n % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check($sformatf("arb_grant%0d", n), {30'd0, i_done, d_done}, {30'd0, ~exp_d, exp_d});
      if (n == 3) d_req = 1'b0;
      tick();
    end
    tick();
    tick();
    check("arb_i_after", {30'd0, i_done, d_done}, 32'd2);
    check("arb_rdata", {i_rdata, d_rdata}, 32'hBEEF1234);
    i_req = 1'b0;
    tick();

    // WAIT_STATES=3: D read keeps mem_en for 4 cycles, done in cycle 5
    d3_req = 1'b1; d3_addr = 16'h0040;
    en_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (mem3_en) en_cnt++;
    end
    check("ws3_c4_nodone", {31'd0, d3_done}, 32'd0);
    check("ws3_en_cycles", en_cnt, 32'd4);
    tick();
    check("ws3_c5_done", {14'd0, mem3_en, d3_done, d3_rdata}, 32'h0001ABCD);
    d3_req = 1'b0;
    tick();
    check("ws3_c6_idle", {30'd0, busy3, d3_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, 16-bit-wide unified memory between the instruction-fetch requester (I) and the data requester (D).
- Serialises accesses and inserts a programmable number of wait states to model slower memory.
- Returns read data through registered per-requester response paths.
- Sequences the memory's dump strobe so a dump never collides with an access.

Parameters:
WAIT_STATES, 0, extra ACCESS cycles per transaction (0..15); counter width 4 bits
ADDR_W, 16, address width of all address ports
DATA_W, 16, data width of all data ports

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
i_req  in  1  fetch request, held until i_done
i_addr  in  ADDR_W  fetch word address, stable while i_req
i_rdata  out  DATA_W  registered fetch read data
i_done  out  1  one-cycle completion pulse for I
d_req  in  1  data request, held until d_done
d_wr  in  1  1 = write, 0 = read, stable while d_req
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  registered data read result
d_done  out  1  one-cycle completion pulse for D
dump_req  in  1  request a memory dump (pulse)
mem_en  out  1  memory enable
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data
mem_dump  out  1  memory dump strobe
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, owner=I, last_owner=I, dump_pending=0. All outputs 0, including i_rdata and d_rdata.
- Reset mid-transaction aborts it with no done pulse. The write is not guaranteed to land, because mem_en drops immediately.
- FSM states:
  - IDLE: requests are sampled only here.
    - On an edge with any req: latch owner, addr, wr (I is always a read), and wdata; set cnt=WAIT_STATES; go to ACCESS.
    - mem_en=0 in IDLE.
  - ACCESS: mem_en=1; mem_wr, mem_addr and mem_wdata are driven from the latched registers.
    - If cnt!=0: decrement cnt and stay.
    - If cnt==0: on a read, capture mem_rdata into the owner's rdata register; go to RESP.
  - RESP: mem_en=0; the owner's done=1 for exactly this cycle; go to IDLE.
- Latency: done is high in cycle N+2+WAIT_STATES, where cycle N is the IDLE cycle in which req is sampled. Maximum throughput is one transaction per 3+WAIT_STATES cycles.
- Handshake rules:
  - The requester holds req and operands stable until its done.
  - The requester deasserts req in the done cycle unless it is issuing a back-to-back request. A req still high in the following IDLE cycle is a new transaction.
- Response data:
  - rdata holds its value until the next read by the same owner.
  - Writes leave d_rdata unchanged.
  - The non-owner's rdata and done are never disturbed.
- Arbitration, simultaneous i_req and d_req in IDLE: see Optional Feature. The losing request stays pending and is served next.
- Dump sequencing:
  - A dump_req high on any edge sets dump_pending.
  - In IDLE with dump_pending=1 and no req, mem_dump=1 for one cycle and dump_pending clears.
  - Requests take priority over a pending dump. Every write completed before that point is therefore included in the dump.
- Address wrap: addresses pass through unmodified. 16'hFFFF is legal.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - On a conflict, the requester that is not last_owner wins.
  - last_owner updates on every grant.
  - Reset last_owner=I, so the first conflict goes to D.
- Undefined: fixed priority; D always wins conflicts and last_owner is unused. This permits I starvation under continuous d_req.

Test Plan:
- WAIT_STATES=0; mem preloaded 0x0010=16'hBEEF; i_req, i_addr=0x0010 sampled in cycle 0 -> mem_en=1, mem_addr=0x0010 in cycle 1; i_done=1 and i_rdata=16'hBEEF in cycle 2; busy=0 in cycle 3.
- D write 0x0020<=16'h1234, then D read 0x0020 back-to-back -> d_rdata=16'h1234 on the second d_done; d_rdata unchanged after the write's d_done.
- WAIT_STATES=3; D read -> mem_en high for exactly 4 cycles; d_done in cycle 5 after sampling.
- i_req and d_req both held from reset release:
  - Without the macro: D, D, D... while d_req stays high; i_done never asserts until d_req drops.
  - With ARB_ROUND_ROBIN_EN: grants alternate D, I, D, I.
- dump_req pulsed during an ACCESS of a D write to 0x0030 -> mem_dump asserts once, in the first IDLE cycle with no req, after d_done.
- Assert rst=0 in the middle of ACCESS -> mem_en, busy, done and rdata go to 0 immediately. After release, state is IDLE and a fresh request completes normally.
